// File: rtl/sym_vn_lut_loader.sv
// sym_vn_lut_loader
//   Write-side sequencer for the two-bank symmetric VN LUT RAM. A load command
//   selects one frame slot. Every page of that slot is then written from a
//   valid/ready stream of entry pairs, one entry per bank per beat. Completion
//   is reported to the iteration controller with a one-cycle pulse.
//
// Ports
//   write_clk, rst      clock shared with the RAM write port; async active-high reset
//   load_start          one-cycle load request (honoured only when idle)
//   load_frame          frame slot to fill, sampled with load_start
//   load_abort          terminates a load in progress
//   lut_lock            holds off acceptance while the decoder must not see writes
//   in_valid/in_data    entry pair; low half -> bank0, high half -> bank1
//   in_ready            combinational accept qualifier
//   lut_in_bank0/1      registered RAM write data
//   page_write_addr     registered page address
//   write_addr_offset   registered frame offset
//   we                  registered write enable, one cycle per accepted beat
//   busy                a load is in progress
//   load_done           one-cycle pulse coincident with the last page write
module sym_vn_lut_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2
) (
  input  logic                                          write_clk,
  input  logic                                          rst,
  input  logic                                          load_start,
  input  logic [$clog2(MULTI_FRAME_NUM)-1:0]            load_frame,
  input  logic                                          load_abort,
  input  logic                                          lut_lock,
  input  logic                                          in_valid,
  input  logic [2*QUAN_SIZE-1:0]                        in_data,
  output logic                                          in_ready,
  output logic [QUAN_SIZE-1:0]                          lut_in_bank0,
  output logic [QUAN_SIZE-1:0]                          lut_in_bank1,
  output logic [ENTRY_ADDR-$clog2(MULTI_FRAME_NUM)-1:0] page_write_addr,
  output logic [$clog2(MULTI_FRAME_NUM)-1:0]            write_addr_offset,
  output logic                                          we,
  output logic                                          busy,
  output logic                                          load_done
);

  localparam int FRAME_W  = $clog2(MULTI_FRAME_NUM);
  localparam int PAGE_W   = ENTRY_ADDR - FRAME_W;
  localparam int PAGE_NUM = 2 ** PAGE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PAGE_W-1:0]      page_cnt_q, page_cnt_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [QUAN_SIZE-1:0]   bank0_q, bank0_d;
  logic [QUAN_SIZE-1:0]   bank1_q, bank1_d;
  logic [PAGE_W-1:0]      page_addr_q, page_addr_d;
  logic [FRAME_W-1:0]     offset_q, offset_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept;

  // Abort wins over a same-cycle beat by withdrawing ready.
  assign in_ready = (state_q == LOAD) & ~lut_lock & ~load_abort;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      page_cnt_q  <= '0;
      frame_q     <= '0;
      bank0_q     <= '0;
      bank1_q     <= '0;
      page_addr_q <= '0;
      offset_q    <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_cnt_q  <= page_cnt_d;
      frame_q     <= frame_d;
      bank0_q     <= bank0_d;
      bank1_q     <= bank1_d;
      page_addr_q <= page_addr_d;
      offset_q    <= offset_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    page_cnt_d  = page_cnt_q;
    frame_d     = frame_q;
    bank0_d     = bank0_q;
    bank1_d     = bank1_q;
    page_addr_d = page_addr_q;
    offset_d    = offset_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (load_start) begin
          frame_d    = load_frame;
          page_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        busy_d = 1'b1;
        if (load_abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          we_d        = 1'b1;
          bank0_d     = in_data[QUAN_SIZE-1:0];
          bank1_d     = in_data[2*QUAN_SIZE-1:QUAN_SIZE];
          page_addr_d = page_cnt_q;
          offset_d    = frame_q;
          page_cnt_d  = page_cnt_q + PAGE_W'(1);
          // The last page's write and the completion pulse share the DONE cycle.
          if (page_cnt_q == PAGE_W'(PAGE_NUM - 1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign lut_in_bank0      = bank0_q;
  assign lut_in_bank1      = bank1_q;
  assign page_write_addr   = page_addr_q;
  assign write_addr_offset = offset_q;
  assign we                = we_q;
  assign busy              = busy_q;
  assign load_done         = done_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// tb_sym_vn_lut_loader
//   Scoreboard bench for sym_vn_lut_loader. The stimulus side keeps a
//   transaction-level model of the load and queues every expected RAM write
//   together with the cycle it must appear in. An independent monitor matches
//   the DUT's write port against that queue.
module tb_sym_vn_lut_loader;

  localparam int QUAN_SIZE       = 3;
  localparam int ENTRY_ADDR      = 5;
  localparam int MULTI_FRAME_NUM = 2;
  localparam int FRAME_W         = 1;
  localparam int PAGE_W          = 4;
  localparam int PAGE_NUM        = 16;

  logic                   write_clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   load_start = 1'b0;
  logic [FRAME_W-1:0]     load_frame = '0;
  logic                   load_abort = 1'b0;
  logic                   lut_lock = 1'b0;
  logic                   in_valid = 1'b0;
  logic [2*QUAN_SIZE-1:0] in_data = '0;
  logic                   in_ready;
  logic [QUAN_SIZE-1:0]   lut_in_bank0, lut_in_bank1;
  logic [PAGE_W-1:0]      page_write_addr;
  logic [FRAME_W-1:0]     write_addr_offset;
  logic                   we, busy, load_done;

  sym_vn_lut_loader #(
    .QUAN_SIZE(QUAN_SIZE),
    .ENTRY_ADDR(ENTRY_ADDR),
    .MULTI_FRAME_NUM(MULTI_FRAME_NUM)
  ) dut (
    .write_clk(write_clk),
    .rst(rst),
    .load_start(load_start),
    .load_frame(load_frame),
    .load_abort(load_abort),
    .lut_lock(lut_lock),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .lut_in_bank0(lut_in_bank0),
    .lut_in_bank1(lut_in_bank1),
    .page_write_addr(page_write_addr),
    .write_addr_offset(write_addr_offset),
    .we(we),
    .busy(busy),
    .load_done(load_done)
  );

  always #5 write_clk = ~write_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge write_clk) cyc <= cyc + 1;

  typedef struct {
    int b0;
    int b1;
    int page;
    int off;
    int last;
    int at;
  } wr_t;
  wr_t sb[$];

  // Transaction-level view of the loader.
  bit m_loading = 1'b0;
  bit m_finish  = 1'b0;
  int m_page    = 0;
  int m_frame   = 0;
  int n_acc     = 0;
  int exp_done  = 0;
  int seen_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the inputs as currently driven.
  task automatic tick();
    bit rdy;
    @(negedge write_clk);
    rdy = m_loading && !lut_lock && !load_abort;
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("busy", 32'(busy), 32'(m_loading || m_finish));
    if (m_finish) begin
      m_finish = 1'b0;
    end else if (!m_loading) begin
      if (load_start) begin
        m_loading = 1'b1;
        m_frame   = int'(load_frame);
        m_page    = 0;
        n_acc     = 0;
      end
    end else if (load_abort) begin
      m_loading = 1'b0;
    end else if (in_valid && rdy) begin
      sb.push_back('{int'(in_data[2:0]), int'(in_data[5:3]), m_page, m_frame,
                     (m_page == PAGE_NUM - 1) ? 1 : 0, cyc + 1});
      m_page++;
      n_acc++;
      if (m_page == PAGE_NUM) begin
        m_loading = 1'b0;
        m_finish  = 1'b1;
        exp_done++;
      end
    end
    @(posedge write_clk);
    #1;
  endtask

  task automatic start(input int f, input bit with_abort);
    load_start = 1'b1;
    load_frame = FRAME_W'(f);
    load_abort = with_abort;
    tick();
    load_start = 1'b0;
    load_abort = 1'b0;
  endtask

  // Offer beats until `target` pages have been accepted in this load.
  task automatic stream(input int target, input int pct, input bit det, input bit rlock);
    int guard;
    guard = 0;
    while (m_loading && n_acc < target && guard < 400) begin
      in_valid = ($urandom_range(99) < pct);
      if (det) in_data = {3'(7 - (n_acc % 8)), 3'(n_acc % 8)};
      else     in_data = 6'($urandom);
      lut_lock = rlock && ($urandom_range(7) == 0);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    lut_lock = 1'b0;
    if (guard >= 400) check("stream_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: every write must match the head of the scoreboard in content
  // and cycle; between writes the data/address outputs must hold.
  initial begin
    wr_t e;
    int last_b0, last_b1, last_pg, last_off;
    last_b0 = 0; last_b1 = 0; last_pg = 0; last_off = 0;
    forever begin
      @(negedge write_clk);
      if (rst) begin
        last_b0 = 0; last_b1 = 0; last_pg = 0; last_off = 0;
      end else begin
        if (load_done) seen_done++;
        if (we) begin
          if (sb.size() == 0) begin
            check("spurious_we", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("wr_cycle", 32'(cyc), 32'(e.at));
            check("bank0", 32'(lut_in_bank0), 32'(e.b0));
            check("bank1", 32'(lut_in_bank1), 32'(e.b1));
            check("page", 32'(page_write_addr), 32'(e.page));
            check("offset", 32'(write_addr_offset), 32'(e.off));
            check("load_done", 32'(load_done), 32'(e.last));
            last_b0 = e.b0; last_b1 = e.b1; last_pg = e.page; last_off = e.off;
          end
        end else begin
          check("done_without_we", 32'(load_done), 32'd0);
          check("hold_page", 32'(page_write_addr), 32'(last_pg));
          check("hold_offset", 32'(write_addr_offset), 32'(last_off));
          check("hold_bank0", 32'(lut_in_bank0), 32'(last_b0));
          check("hold_bank1", 32'(lut_in_bank1), 32'(last_b1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_bank0"}, 32'(lut_in_bank0), 32'd0);
    check({tag, "_bank1"}, 32'(lut_in_bank1), 32'd0);
    check({tag, "_page"}, 32'(page_write_addr), 32'd0);
    check({tag, "_offset"}, 32'(write_addr_offset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (3) @(posedge write_clk);
    #1 rst = 1'b0;
    tick();

    // Back-to-back load of frame 0 with the patterned data.
    start(0, 1'b0);
    stream(PAGE_NUM, 100, 1'b1, 1'b0);
    tick();
    tick();

    // Frame 1: gaps, a lock window and an ignored mid-load start.
    start(1, 1'b0);
    stream(2, 100, 1'b0, 1'b0);
    tick();
    tick();
    stream(6, 100, 1'b0, 1'b0);
    lut_lock = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    lut_lock   = 1'b0;
    load_start = 1'b1;
    load_frame = '0;
    tick();
    load_start = 1'b0;
    stream(PAGE_NUM, 70, 1'b0, 1'b0);
    tick();
    tick();

    // Abort after five pages with a beat offered in the abort cycle.
    start(1, 1'b0);
    stream(5, 100, 1'b0, 1'b0);
    in_valid   = 1'b1;
    load_abort = 1'b1;
    tick();
    in_valid   = 1'b0;
    load_abort = 1'b0;
    tick();
    tick();
    start(0, 1'b1);
    stream(PAGE_NUM, 80, 1'b0, 1'b1);
    tick();
    tick();

    // Asynchronous reset while the eighth page's write is pending.
    start(1, 1'b0);
    stream(8, 100, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check_all_zero("midreset");
    sb.delete();
    m_loading = 1'b0;
    m_finish  = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Start in the completion cycle is dropped; the following one is taken.
    start(0, 1'b0);
    stream(PAGE_NUM, 100, 1'b0, 1'b0);
    load_start = 1'b1;
    load_frame = 1'b1;
    tick();
    tick();
    load_start = 1'b0;
    stream(PAGE_NUM, 100, 1'b0, 1'b0);
    tick();
    tick();

    // Random loads with occasional aborts and lock pulses.
    for (int k = 0; k < 6; k++) begin
      start(int'($urandom_range(1)), 1'b0);
      if ($urandom_range(2) == 0) begin
        stream(int'($urandom_range(PAGE_NUM - 1)), 75, 1'b0, 1'b1);
        load_abort = 1'b1;
        in_valid   = 1'($urandom_range(1));
        tick();
        load_abort = 1'b0;
        in_valid   = 1'b0;
      end else begin
        stream(PAGE_NUM, 75, 1'b0, 1'b1);
      end
      repeat (int'($urandom_range(1, 3))) tick();
    end

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("done_count", 32'(seen_done), 32'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
